// File: rtl/reset_sequencer_pkg.sv
// Shared types and defaults for the staged reset sequencer.
// Define RSTSEQ_TIMEOUT_EN to build the per-stage timeout and the FAULT state.
package rstseq_pkg;

  typedef enum logic [2:0] {HOLD, WAIT, GAP, RUN, FAULT} state_t;

  localparam int unsigned N_STAGE_DEF  = 4;
  localparam int unsigned HOLD_CYC_DEF = 32768;
  localparam int unsigned GAP_CYC_DEF  = 16;
  localparam int unsigned TMO_CYC_DEF  = 4096;

  function automatic int unsigned stage_w(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset-domain handshake bundle: sequencer drives RST_OUT/status, domains drive READY.
// Feature macro RSTSEQ_TIMEOUT_EN only affects the sequencer, not this bundle.
interface reset_sequencer_if
  import rstseq_pkg::*;
#(
  parameter int unsigned N_STAGE = N_STAGE_DEF
) ();

  logic [N_STAGE-1:0]          READY;
  logic                        SOFT_REQ;
  logic [N_STAGE-1:0]          RST_OUT;
  logic                        DONE;
  logic                        BUSY;
  logic                        ERR;
  logic [stage_w(N_STAGE)-1:0] ERR_STAGE;

  modport master (
    input  READY, SOFT_REQ,
    output RST_OUT, DONE, BUSY, ERR, ERR_STAGE
  );

  modport slave (
    output READY, SOFT_REQ,
    input  RST_OUT, DONE, BUSY, ERR, ERR_STAGE
  );

endinterface

// File: rtl/reset_sequencer_timer.sv
// Loadable saturating down-counter shared by the HOLD, WAIT and GAP phases.
// Independent of RSTSEQ_TIMEOUT_EN; reset is applied by the owner through load.
module rstseq_timer #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge CLK) begin
    if (load)
      value <= load_val;
    else if (value != '0)
      value <= value - W'(1);
  end

  assign zero = (value == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases N_STAGE domains in order, each gated by READY.
// Define RSTSEQ_TIMEOUT_EN to enable per-stage timeout, ERR/ERR_STAGE and FAULT.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int unsigned N_STAGE  = N_STAGE_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned GAP_CYC  = GAP_CYC_DEF,
  parameter int unsigned TMO_CYC  = TMO_CYC_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  reset_sequencer_if.master  bus
);

  localparam int unsigned IW = stage_w(N_STAGE);
`ifdef RSTSEQ_TIMEOUT_EN
  localparam int unsigned CNT_MAX = max2(max2(HOLD_CYC, GAP_CYC), TMO_CYC);
`else
  localparam int unsigned CNT_MAX = max2(HOLD_CYC, GAP_CYC);
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [IW-1:0] LAST = IW'(N_STAGE - 1);

  if (N_STAGE < 1 || N_STAGE > 8 || HOLD_CYC < 1 || TMO_CYC < 1) begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  state_t              state, state_d;
  logic [IW-1:0]       idx, idx_d;
  logic                tmr_load, tmr_zero, tmr_last, ready_cur;
  logic [CNT_W-1:0]    tmr_val, tmr_q;
  logic [N_STAGE-1:0]  rst_out_d;
  logic                done_d, busy_d, err_d;
  logic [IW-1:0]       err_stage_d;

  rstseq_timer #(.W(CNT_W)) u_timer (
    .CLK      (CLK),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_q),
    .zero     (tmr_zero)
  );

  // HOLD and WAIT are loaded with the full cycle count and end on the edge that sees 1.
  assign tmr_last = (tmr_q <= CNT_W'(1));

  always_comb begin
    ready_cur = 1'b0;
    for (int unsigned j = 0; j < N_STAGE; j++)
      if (IW'(j) == idx) ready_cur = bus.READY[j];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= HOLD;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (RST) begin
      state_d  = HOLD;
      idx_d    = '0;
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(HOLD_CYC);
    end else begin
      case (state)
        HOLD: if (tmr_last) begin
          state_d = WAIT;
`ifdef RSTSEQ_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(TMO_CYC);
`endif
        end
        WAIT: begin
          if (ready_cur) begin
            if (idx == LAST) begin
              state_d = RUN;
            end else begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(GAP_CYC);
            end
          end
`ifdef RSTSEQ_TIMEOUT_EN
          else if (tmr_last) begin
            state_d = FAULT;
          end
`endif
        end
        GAP: if (tmr_zero) begin
          state_d = WAIT;
          idx_d   = idx + IW'(1);
`ifdef RSTSEQ_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(TMO_CYC);
`endif
        end
        RUN, FAULT: if (bus.SOFT_REQ) begin
          state_d  = HOLD;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC);
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // Outputs decode the next state so they land on the same edge as the transition.
  always_comb begin
    rst_out_d   = '1;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;
    err_stage_d = '0;
    case (state_d)
      HOLD: busy_d = 1'b1;
      WAIT, GAP: begin
        busy_d = 1'b1;
        for (int unsigned j = 0; j < N_STAGE; j++)
          rst_out_d[j] = (IW'(j) > idx_d);
      end
      RUN: begin
        rst_out_d = '0;
        done_d    = 1'b1;
      end
`ifdef RSTSEQ_TIMEOUT_EN
      FAULT: begin
        err_d       = 1'b1;
        err_stage_d = idx_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    bus.RST_OUT   <= rst_out_d;
    bus.DONE      <= done_d;
    bus.BUSY      <= busy_d;
    bus.ERR       <= err_d;
    bus.ERR_STAGE <= err_stage_d;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed plus randomized bench for reset_sequencer against an event-time reference model.
module tb_reset_sequencer;
  import rstseq_pkg::*;

  localparam int N = 3;
  localparam int H = 8;
  localparam int G = 2;
  localparam int T = 10;
`ifdef RSTSEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reset_sequencer_if #(.N_STAGE(N)) bus ();

  reset_sequencer #(
    .N_STAGE  (N),
    .HOLD_CYC (H),
    .GAP_CYC  (G),
    .TMO_CYC  (T)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: number of released stages and the edge times of pending events.
  longint cyc;
  int     m_nrel;
  longint m_next;
  longint m_relat;
  bit     m_done, m_fault;
  int     m_fs;

  longint   fall_at [N];
  longint   done_at;
  logic [N-1:0] prev_ro;
  logic     prev_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_restart();
    m_nrel  = 0;
    m_next  = cyc + H;
    m_done  = 1'b0;
    m_fault = 1'b0;
    m_fs    = 0;
  endtask

  task automatic model_edge(input bit r, input logic [N-1:0] rdy, input bit s);
    int st;
    if (r) begin
      m_restart();
    end else if ((m_done || m_fault) && s) begin
      m_restart();
    end else if (m_next >= 0) begin
      if (cyc == m_next) begin
        m_nrel++;
        m_relat = cyc;
        m_next  = -1;
      end
    end else if (!m_done && !m_fault && m_nrel > 0) begin
      st = m_nrel - 1;
      if (rdy[st]) begin
        if (st == N - 1) m_done = 1'b1;
        else             m_next = cyc + G + 1;
      end else if (TMO_EN && cyc == m_relat + T) begin
        m_fault = 1'b1;
        m_fs    = st;
      end
    end
  endtask

  task automatic clear_marks();
    for (int j = 0; j < N; j++) fall_at[j] = -1;
    done_at = -1;
  endtask

  task automatic tick();
    logic [N-1:0] exp_ro;
    @(posedge clk);
    cyc++;
    model_edge(rst, bus.READY, bus.SOFT_REQ);
    #1;
    for (int j = 0; j < N; j++) exp_ro[j] = m_fault || (j >= m_nrel);
    chk("model_rst_out", 32'(bus.RST_OUT), 32'(exp_ro));
    chk("model_done", 32'(bus.DONE), 32'(m_done));
    chk("model_busy", 32'(bus.BUSY), 32'(!m_done && !m_fault));
    chk("model_err", 32'(bus.ERR), 32'(m_fault));
    chk("model_err_stage", 32'(bus.ERR_STAGE), m_fault ? 32'(m_fs) : 32'd0);
    for (int j = 0; j < N; j++)
      if (prev_ro[j] === 1'b1 && bus.RST_OUT[j] === 1'b0 && fall_at[j] < 0) fall_at[j] = cyc;
    if (prev_done !== 1'b1 && bus.DONE === 1'b1 && done_at < 0) done_at = cyc;
    prev_ro   = bus.RST_OUT;
    prev_done = bus.DONE;
  endtask

  task automatic wait_fall(input int j, input int limit, input string tag);
    for (int k = 0; k < limit && bus.RST_OUT[j] !== 1'b0; k++) tick();
    chk(tag, 32'(bus.RST_OUT[j]), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_full_seq(input longint e0, input string tag);
    repeat (20) tick();
    chk({tag, "_rel0"}, 32'(fall_at[0] - e0), 32'd7);
    chk({tag, "_rel1"}, 32'(fall_at[1] - e0), 32'd11);
    chk({tag, "_rel2"}, 32'(fall_at[2] - e0), 32'd15);
    chk({tag, "_done"}, 32'(done_at - e0), 32'd16);
  endtask

  initial begin
    longint e0, rsamp, rel;
    checks = 0; errors = 0; cyc = 0;
    m_nrel = 0; m_next = -1; m_relat = 0; m_done = 0; m_fault = 0; m_fs = 0;
    prev_ro = '0; prev_done = 1'b0;
    clear_marks();
    rst = 1'b1;
    bus.READY = '0;
    bus.SOFT_REQ = 1'b0;

    // Reset state and nominal sequence with READY tied high
    tick();
    chk("reset_rst_out", 32'(bus.RST_OUT), 32'h7);
    chk("reset_done", 32'(bus.DONE), 32'd0);
    chk("reset_busy", 32'(bus.BUSY), 32'd1);
    chk("reset_err", 32'(bus.ERR), 32'd0);
    chk("reset_err_stage", 32'(bus.ERR_STAGE), 32'd0);
    bus.READY = 3'b111;
    tick();
    rst = 1'b0;
    e0 = cyc + 1;
    clear_marks();
    check_full_seq(e0, "nominal");

    // Late READY on stage 1
    do_reset();
    bus.READY = 3'b101;
    clear_marks();
    wait_fall(1, 40, "late_wait_rel1");
    repeat (4) tick();
    bus.READY = 3'b111;
    rsamp = cyc + 1;
    repeat (8) tick();
    chk("late_rel2", 32'(fall_at[2] - rsamp), 32'd3);
    chk("late_err", 32'(bus.ERR), 32'd0);

`ifdef RSTSEQ_TIMEOUT_EN
    // Stage 1 never ready: timeout, hold, then software restart
    do_reset();
    bus.READY = 3'b101;
    wait_fall(1, 40, "tmo_wait_rel1");
    rel = cyc;
    repeat (9) tick();
    chk("tmo_err_early", 32'(bus.ERR), 32'd0);
    tick();
    chk("tmo_when", 32'(cyc - rel), 32'd10);
    chk("tmo_err", 32'(bus.ERR), 32'd1);
    chk("tmo_err_stage", 32'(bus.ERR_STAGE), 32'd1);
    chk("tmo_rst_out", 32'(bus.RST_OUT), 32'h7);
    chk("tmo_busy", 32'(bus.BUSY), 32'd0);
    repeat (50) tick();
    chk("tmo_hold_err", 32'(bus.ERR), 32'd1);
    chk("tmo_hold_rst_out", 32'(bus.RST_OUT), 32'h7);
    bus.SOFT_REQ = 1'b1;
    tick();
    bus.SOFT_REQ = 1'b0;
    chk("soft_err", 32'(bus.ERR), 32'd0);
    chk("soft_done", 32'(bus.DONE), 32'd0);
    chk("soft_rst_out", 32'(bus.RST_OUT), 32'h7);
    e0 = cyc + 1;
    clear_marks();
    bus.READY = 3'b111;
    repeat (2) tick();
    bus.SOFT_REQ = 1'b1;
    tick();
    bus.SOFT_REQ = 1'b0;
    check_full_seq(e0, "soft_rerun");
`else
    // Without timeout, stage 0 waits indefinitely
    do_reset();
    bus.READY = 3'b000;
    repeat (1000) tick();
    chk("stuck_err", 32'(bus.ERR), 32'd0);
    chk("stuck_rst_out", 32'(bus.RST_OUT), 32'h6);
    clear_marks();
    bus.READY = 3'b111;
    rsamp = cyc + 1;
    repeat (12) tick();
    chk("stuck_rel1", 32'(fall_at[1] - rsamp), 32'd3);
    chk("stuck_rel2", 32'(fall_at[2] - rsamp), 32'd7);
    chk("stuck_done", 32'(done_at - rsamp), 32'd8);
`endif

    // One-cycle RST while waiting on stage 2
    do_reset();
    bus.READY = 3'b011;
    wait_fall(2, 40, "rst_wait_rel2");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rst_out", 32'(bus.RST_OUT), 32'h7);
    chk("midrst_done", 32'(bus.DONE), 32'd0);
    chk("midrst_busy", 32'(bus.BUSY), 32'd1);
    e0 = cyc + 1;
    clear_marks();
    bus.READY = 3'b111;
    check_full_seq(e0, "midrst");

    // Randomized READY, SOFT_REQ and RST against the model
    for (int i = 0; i < 3000; i++) begin
      bus.READY    = 3'($urandom & $urandom);
      bus.SOFT_REQ = ($urandom_range(0, 49) == 0);
      rst          = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.SOFT_REQ = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
